// File: rtl/tcp_server_fsm.sv
// tcp_server_fsm
// Responder side of the TCP three-way handshake. It waits in LISTEN for a SYN
// and answers with a SYN-ACK. It then waits in SYN_RCVD for the final ACK and
// reports ESTABLISHED once that ACK checks out.
//
// In SYN_RCVD it also:
//   - retransmits the SYN-ACK on timeout and gives up after MAX_RETRY retries
//     (conn_fail pulse);
//   - answers a bad ACK with an RST;
//   - drops back to LISTEN on a received RST.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   rx_valid            : single-cycle qualifier for the incoming segment
//   rx_syn/ack/rst      : incoming flags
//   rx_seq, rx_ack_num  : incoming sequence / acknowledgement numbers
//   tx_valid            : one-cycle strobe for an outgoing segment
//   tx_syn/ack/rst      : outgoing flags (zero whenever tx_valid is low)
//   tx_seq, tx_ack_num  : outgoing numbers (zero whenever tx_valid is low)
//   established         : level, high while in ESTABLISHED
//   conn_fail           : one-cycle pulse when retransmits are exhausted
//   state               : current state (debug)
module tcp_server_fsm #(
    parameter int               SEQ_W       = 8,
    parameter logic [SEQ_W-1:0] ISN         = SEQ_W'(200),
    parameter int               TIMEOUT_CYC = 16,
    parameter int               MAX_RETRY   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic             rx_syn,
    input  logic             rx_ack,
    input  logic             rx_rst,
    input  logic [SEQ_W-1:0] rx_seq,
    input  logic [SEQ_W-1:0] rx_ack_num,
    output logic             tx_valid,
    output logic             tx_syn,
    output logic             tx_ack,
    output logic             tx_rst,
    output logic [SEQ_W-1:0] tx_seq,
    output logic [SEQ_W-1:0] tx_ack_num,
    output logic             established,
    output logic             conn_fail,
    output logic [1:0]       state
);

    localparam int TW = (TIMEOUT_CYC < 2) ? 2 : $clog2(TIMEOUT_CYC + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [SEQ_W-1:0] ISN_P1 = ISN + SEQ_W'(1);

    typedef enum logic [1:0] {
        LISTEN      = 2'b00,
        SYN_RCVD    = 2'b01,
        ESTABLISHED = 2'b10
    } state_t;

    typedef struct packed {
        logic             syn;
        logic             ack;
        logic             rst;
        logic [SEQ_W-1:0] seq;
        logic [SEQ_W-1:0] ack_num;
    } seg_t;

    state_t           cur_state;
    seg_t             tx_q;
    logic             tx_valid_q;
    logic             established_q;
    logic             conn_fail_q;
    logic [TW-1:0]    timer;
    logic [RW-1:0]    retry;
    logic [SEQ_W-1:0] irs;

    // Segment classification
    logic             [SEQ_W-1:0] irs_p1;
    logic             syn_open;
    logic             ack_only;
    logic             ack_ok;
    logic             ack_bad;
    logic             dup_syn;
    logic             rst_in;
    logic             tmo;

    assign irs_p1   = irs + SEQ_W'(1);
    assign syn_open = rx_valid & rx_syn & ~rx_ack & ~rx_rst;
    assign ack_only = rx_valid & rx_ack & ~rx_syn & ~rx_rst;
    assign ack_ok   = ack_only & (rx_ack_num == ISN_P1) & (rx_seq == irs_p1);
    // A right ack_num with a wrong seq is neither ok nor bad: it is ignored.
    assign ack_bad  = ack_only & (rx_ack_num != ISN_P1);
    assign dup_syn  = rx_valid & rx_syn & ~rx_ack & (rx_seq == irs);
    assign rst_in   = rx_valid & rx_rst;
    // Timer is loaded with TIMEOUT_CYC and expires on the edge where it would
    // step from 1 to 0, so expiry lands exactly TIMEOUT_CYC cycles after the load.
    assign tmo      = (timer <= TW'(1));

    function automatic seg_t syn_ack(input logic [SEQ_W-1:0] an);
        seg_t s;
        s.syn     = 1'b1;
        s.ack     = 1'b1;
        s.rst     = 1'b0;
        s.seq     = ISN;
        s.ack_num = an;
        return s;
    endfunction

    function automatic seg_t rst_seg(input logic [SEQ_W-1:0] sq);
        seg_t s;
        s         = '0;
        s.rst     = 1'b1;
        s.seq     = sq;
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state     <= LISTEN;
            tx_valid_q    <= 1'b0;
            tx_q          <= '0;
            established_q <= 1'b0;
            conn_fail_q   <= 1'b0;
            timer         <= '0;
            retry         <= '0;
            irs           <= '0;
        end else begin
            // Strobes and tx fields default low every cycle.
            tx_valid_q  <= 1'b0;
            tx_q        <= '0;
            conn_fail_q <= 1'b0;
            case (cur_state)
                LISTEN: begin
                    established_q <= 1'b0;
                    if (syn_open) begin
                        cur_state  <= SYN_RCVD;
                        irs        <= rx_seq;
                        tx_valid_q <= 1'b1;
                        tx_q       <= syn_ack(rx_seq + SEQ_W'(1));
                        timer      <= TW'(TIMEOUT_CYC);
                        retry      <= '0;
                    end
                end
                SYN_RCVD: begin
                    if (rst_in) begin
                        cur_state <= LISTEN;
                        timer     <= '0;
                        retry     <= '0;
                    end else if (ack_ok) begin
                        cur_state     <= ESTABLISHED;
                        established_q <= 1'b1;
                        timer         <= '0;
                        retry         <= '0;
                    end else if (tmo) begin
                        if (retry < RW'(MAX_RETRY)) begin
                            tx_valid_q <= 1'b1;
                            tx_q       <= syn_ack(irs_p1);
                            retry      <= retry + RW'(1);
                            timer      <= TW'(TIMEOUT_CYC);
                        end else begin
                            conn_fail_q <= 1'b1;
                            cur_state   <= LISTEN;
                            timer       <= '0;
                            retry       <= '0;
                        end
                    end else if (ack_bad) begin
                        tx_valid_q <= 1'b1;
                        tx_q       <= rst_seg(rx_ack_num);
                        cur_state  <= LISTEN;
                        timer      <= '0;
                        retry      <= '0;
                    end else if (dup_syn) begin
                        // Peer resent its SYN: resend SYN-ACK without spending a retry.
                        tx_valid_q <= 1'b1;
                        tx_q       <= syn_ack(irs_p1);
                        timer      <= TW'(TIMEOUT_CYC);
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ESTABLISHED: begin
                    if (rst_in) begin
                        cur_state     <= LISTEN;
                        established_q <= 1'b0;
                    end
                end
                default: begin
                    cur_state     <= LISTEN;
                    established_q <= 1'b0;
                    timer         <= '0;
                    retry         <= '0;
                end
            endcase
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_syn      = tx_q.syn;
    assign tx_ack      = tx_q.ack;
    assign tx_rst      = tx_q.rst;
    assign tx_seq      = tx_q.seq;
    assign tx_ack_num  = tx_q.ack_num;
    assign established = established_q;
    assign conn_fail   = conn_fail_q;
    assign state       = cur_state;

endmodule

// File: tb/tb_tcp_server_fsm.sv
module tb_tcp_server_fsm;
    localparam int         SEQ_W = 8;
    localparam logic [7:0] ISN   = 8'd200;
    localparam int         TMO   = 16;
    localparam int         MAXR  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0, rx_syn = 1'b0, rx_ack = 1'b0, rx_rst = 1'b0;
    logic [7:0] rx_seq = '0, rx_ack_num = '0;
    logic       tx_valid, tx_syn, tx_ack, tx_rst;
    logic [7:0] tx_seq, tx_ack_num;
    logic       established, conn_fail;
    logic [1:0] state;

    tcp_server_fsm #(.SEQ_W(SEQ_W), .ISN(ISN), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_syn(rx_syn), .rx_ack(rx_ack), .rx_rst(rx_rst),
        .rx_seq(rx_seq), .rx_ack_num(rx_ack_num),
        .tx_valid(tx_valid), .tx_syn(tx_syn), .tx_ack(tx_ack), .tx_rst(tx_rst),
        .tx_seq(tx_seq), .tx_ack_num(tx_ack_num),
        .established(established), .conn_fail(conn_fail), .state(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    typedef struct {
        int         cyc;
        logic       syn, ack, rst;
        logic [7:0] seq, an;
    } tx_exp_t;
    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       est;
    } st_exp_t;

    tx_exp_t tx_q[$];
    st_exp_t st_q[$];
    int      cf_q[$];

    // Reference model: connection phase, peer ISN and an absolute-cycle deadline.
    int         m_phase = 0;   // 0 listen, 1 syn received, 2 established
    logic [7:0] m_irs = '0;
    int         m_deadline = 0;
    int         m_retries = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_tx(input int e, input logic s, input logic a, input logic r,
                           input logic [7:0] sq, input logic [7:0] an);
        tx_exp_t t;
        t.cyc = e; t.syn = s; t.ack = a; t.rst = r; t.seq = sq; t.an = an;
        tx_q.push_back(t);
    endtask

    // Predict the effect of the inputs currently driven, at the coming edge.
    task automatic model_step();
        int      e;
        st_exp_t s;
        logic    ackseg;
        e = cyc + 1;
        ackseg = rx_valid && rx_ack && !rx_syn && !rx_rst;
        case (m_phase)
            0: if (rx_valid && rx_syn && !rx_ack && !rx_rst) begin
                m_phase = 1;
                m_irs = rx_seq;
                m_deadline = e + TMO;
                m_retries = 0;
                push_tx(e, 1, 1, 0, ISN, rx_seq + 8'd1);
            end
            1: begin
                if (rx_valid && rx_rst) m_phase = 0;
                else if (ackseg && rx_ack_num == ISN + 8'd1 && rx_seq == m_irs + 8'd1) m_phase = 2;
                else if (e == m_deadline) begin
                    if (m_retries < MAXR) begin
                        m_retries++;
                        m_deadline = e + TMO;
                        push_tx(e, 1, 1, 0, ISN, m_irs + 8'd1);
                    end else begin
                        cf_q.push_back(e);
                        m_phase = 0;
                    end
                end else if (ackseg && rx_ack_num != ISN + 8'd1) begin
                    push_tx(e, 0, 0, 1, rx_ack_num, 8'd0);
                    m_phase = 0;
                end else if (rx_valid && rx_syn && !rx_ack && rx_seq == m_irs) begin
                    m_deadline = e + TMO;
                    push_tx(e, 1, 1, 0, ISN, m_irs + 8'd1);
                end
            end
            default: if (rx_valid && rx_rst) m_phase = 0;
        endcase
        s.cyc = e;
        s.st = 2'(m_phase);
        s.est = (m_phase == 2);
        st_q.push_back(s);
    endtask

    task automatic seg(input logic v, input logic s, input logic a, input logic r,
                       input logic [7:0] sq, input logic [7:0] an);
        @(negedge clk);
        rx_valid = v; rx_syn = s; rx_ack = a; rx_rst = r; rx_seq = sq; rx_ack_num = an;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) seg(0, 0, 0, 0, 8'd0, 8'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {8'd0, tx_valid, tx_syn, tx_ack, tx_rst, tx_seq, tx_ack_num,
                   established, conn_fail, state}, 32'd0);
    endtask

    // Assert reset between edges, verify outputs clear before the next edge.
    task automatic do_reset();
        @(negedge clk);
        rx_valid = 0; rx_syn = 0; rx_ack = 0; rx_rst = 0;
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_reset_outputs");
        m_phase = 0; m_retries = 0; m_deadline = 0; m_irs = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_step();
    endtask

    // Monitor: compares DUT outputs with queued expectations after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset || !started) continue;
            if (st_q.size() == 0) fail("state_queue_underflow");
            else begin
                st_exp_t s;
                s = st_q.pop_front();
                chk("state_stamp", 32'(s.cyc), 32'(cyc));
                chk("state", {30'd0, state}, {30'd0, s.st});
                chk("established", {31'd0, established}, {31'd0, s.est});
            end
            while (tx_q.size() > 0 && tx_q[0].cyc < cyc) begin
                chk("missed_tx_at", 32'(cyc), 32'(tx_q[0].cyc));
                void'(tx_q.pop_front());
            end
            if (tx_valid) begin
                if (tx_q.size() == 0 || tx_q[0].cyc != cyc)
                    chk("unexpected_tx_valid", {31'd0, tx_valid}, 32'd0);
                else begin
                    tx_exp_t t;
                    t = tx_q.pop_front();
                    chk("tx_segment", {13'd0, tx_syn, tx_ack, tx_rst, tx_seq, tx_ack_num},
                        {13'd0, t.syn, t.ack, t.rst, t.seq, t.an});
                end
            end else
                chk("tx_idle_zero", {13'd0, tx_syn, tx_ack, tx_rst, tx_seq, tx_ack_num}, 32'd0);
            while (cf_q.size() > 0 && cf_q[0] < cyc) begin
                chk("missed_conn_fail_at", 32'(cyc), 32'(cf_q[0]));
                void'(cf_q.pop_front());
            end
            if (conn_fail) begin
                if (cf_q.size() == 0 || cf_q[0] != cyc)
                    chk("unexpected_conn_fail", {31'd0, conn_fail}, 32'd0);
                else void'(cf_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sq, an;
        #3 reset = 1'b0;
        #1 check_reset_outputs("power_on_reset_outputs");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        started = 1;
        model_step();

        // Basic handshake
        seg(1, 1, 0, 0, 8'd100, 8'd0);
        idle(2);
        seg(1, 1, 0, 0, 8'd100, 8'd0);
        seg(1, 0, 1, 0, 8'd101, 8'd201);
        idle(3);
        // RST while established
        seg(1, 0, 0, 1, 8'd0, 8'd0);
        idle(2);

        // Sequence wrap
        seg(1, 1, 0, 0, 8'd255, 8'd0);
        idle(1);
        seg(1, 0, 1, 0, 8'd0, 8'd201);
        idle(2);
        seg(1, 0, 0, 1, 8'd0, 8'd0);
        idle(2);

        // Full timeout, then an immediate new SYN
        seg(1, 1, 0, 0, 8'd50, 8'd0);
        idle(64);
        seg(1, 1, 0, 0, 8'd7, 8'd0);
        idle(1);
        // Bad ACK -> RST
        seg(1, 0, 1, 0, 8'd8, 8'd150);
        idle(2);

        // Valid ACK on the expiry cycle
        seg(1, 1, 0, 0, 8'd100, 8'd0);
        idle(15);
        seg(1, 0, 1, 0, 8'd101, 8'd201);
        idle(2);
        seg(1, 0, 0, 1, 8'd0, 8'd0);
        idle(2);

        // Duplicate SYN: retransmit without consuming a retry
        seg(1, 1, 0, 0, 8'd100, 8'd0);
        idle(5);
        seg(1, 1, 0, 0, 8'd100, 8'd0);
        seg(1, 1, 0, 0, 8'd99, 8'd0);
        seg(1, 0, 1, 0, 8'd55, 8'd201);
        idle(70);

        // Reset during SYN_RCVD while the SYN-ACK is on the outputs
        seg(1, 1, 0, 0, 8'd30, 8'd0);
        do_reset();
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 4) do_reset();
            else if (r < 12) idle(int'($urandom_range(16, 50)));
            else if (r < 250) begin
                case ($urandom_range(0, 3))
                    0: sq = m_irs;
                    1: sq = m_irs + 8'd1;
                    default: sq = 8'($urandom);
                endcase
                an = ($urandom_range(0, 1) == 1) ? ISN + 8'd1 : 8'($urandom);
                seg(1, 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0), sq, an);
            end else idle(1);
        end

        idle(5);
        @(posedge clk);
        #2;
        chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        chk("conn_fail_queue_drained", 32'(cf_q.size()), 32'd0);
        chk("state_queue_drained", 32'(st_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tcp_server_fsm.md
Name: tcp_server_fsm

Overview:
Passive-open (responder) side of the three-way TCP handshake. It pairs with the client handshake FSM already in the design.
- Waits in LISTEN for a SYN.
- Answers with SYN-ACK.
- Validates the final ACK, then reports ESTABLISHED.
- Handles SYN-ACK retransmission on timeout, RST generation on a bad ACK, and RST reception.
Segment fields arrive/leave as parallel flags plus sequence/ack numbers; there is no payload path.

Parameters:
SEQ_W, 8, width of sequence/ack numbers; all arithmetic is modulo 2^SEQ_W.
ISN, 8'd200, server initial sequence number (fixed, no generator).
TIMEOUT_CYC, 16, cycles in SYN_RCVD without a valid ACK before SYN-ACK retransmit (>=2).
MAX_RETRY, 3, number of retransmits before giving up.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
rx_valid  input  1  incoming segment present this cycle (single-cycle qualifier)
rx_syn  input  1  incoming SYN flag
rx_ack  input  1  incoming ACK flag
rx_rst  input  1  incoming RST flag
rx_seq  input  SEQ_W  incoming sequence number
rx_ack_num  input  SEQ_W  incoming acknowledgement number
tx_valid  output  1  outgoing segment strobe, one-cycle pulse
tx_syn  output  1  outgoing SYN flag (valid with tx_valid)
tx_ack  output  1  outgoing ACK flag
tx_rst  output  1  outgoing RST flag
tx_seq  output  SEQ_W  outgoing sequence number
tx_ack_num  output  SEQ_W  outgoing acknowledgement number
established  output  1  level, high while in ESTABLISHED
conn_fail  output  1  one-cycle pulse when retries are exhausted
state  output  2  current state, for debug

Behaviour:
- All outputs are registered. reset low forces, asynchronously:
  - state=LISTEN
  - all tx_* = 0, established=0, conn_fail=0
  - timer=0, retry=0, stored irs=0
- tx_* flags and numbers are 0 in any cycle where tx_valid=0.
- States:
  - LISTEN=2'b00, SYN_RCVD=2'b01, ESTABLISHED=2'b10.
  - 2'b11 is illegal and returns to LISTEN on the next clock with no tx.
- Priority within a cycle: rx_rst > valid ACK > retransmit timer > other rx.
- LISTEN:
  - Accepted input: rx_valid & rx_syn & !rx_ack & !rx_rst.
  - Action: latch irs=rx_seq and go to SYN_RCVD.
  - Next cycle: tx_valid=1, tx_syn=1, tx_ack=1, tx_seq=ISN, tx_ack_num=rx_seq+1 (wraps).
  - On accept: timer loads TIMEOUT_CYC, retry=0.
  - All other segments are ignored; no RST is sent from LISTEN.
- SYN_RCVD:
  - Valid ACK = rx_valid & rx_ack & !rx_syn & !rx_rst & rx_ack_num==ISN+1 & rx_seq==irs+1.
    - Goes to ESTABLISHED; established=1 on the following clock.
    - No tx.
  - rx_valid & rx_ack & !rx_syn & !rx_rst with rx_ack_num!=ISN+1:
    - Sends RST next cycle: tx_valid=1, tx_rst=1, tx_seq=rx_ack_num, other flags 0, tx_ack_num=0.
    - Goes to LISTEN.
  - rx_valid & rx_ack with correct ack_num but rx_seq!=irs+1: ignored.
  - rx_valid & rx_rst: go to LISTEN silently.
  - Duplicate SYN (rx_syn & !rx_ack & rx_seq==irs):
    - Retransmit SYN-ACK next cycle.
    - Timer reloads; retry is not incremented.
  - SYN with a different seq: ignored.
  - Timer:
    - Decrements once per cycle in SYN_RCVD.
    - On the cycle it reaches 0 with retry<MAX_RETRY: retransmit SYN-ACK (same ISN/ack_num), retry+1, reload TIMEOUT_CYC.
    - On the cycle it reaches 0 with retry==MAX_RETRY: conn_fail pulse, go to LISTEN, no tx.
  - Valid ACK in the same cycle as timer expiry: ACK wins, no retransmit, no conn_fail.
- ESTABLISHED:
  - rx_valid & rx_rst: go to LISTEN; established=0 next clock.
  - All other segments are ignored (data transfer is out of scope). The state holds indefinitely.
- Timer and retry are cleared on entry to LISTEN.
- A reset assertion mid-handshake aborts immediately, with no RST emitted.
- Back-to-back: a new SYN may be accepted in the first LISTEN cycle after returning.

Test Plan:
1. Handshake (ISN=200): SYN seq=100 -> next cycle tx SYN-ACK seq=200 ack_num=101; then ACK seq=101 ack_num=201 -> established=1 and state=2'b10 one clock later.
2. Wrap: SYN seq=255 -> tx_ack_num=0; ACK seq=0 ack_num=201 -> established=1.
3. Timeout (TIMEOUT_CYC=16, MAX_RETRY=3), no ACK -> SYN-ACK retransmitted 16, 32 and 48 cycles after the first; conn_fail pulses at 64; state=LISTEN; a new SYN seq=7 is accepted immediately after.
4. Bad ACK in SYN_RCVD with ack_num=150 -> next cycle tx_rst=1, tx_seq=150, tx_syn=tx_ack=0; state=LISTEN.
5. RST while in ESTABLISHED -> established=0 and state=LISTEN; reset driven low while in SYN_RCVD -> all outputs 0 immediately, before the next clock edge.
6. Valid ACK on the exact timer-expiry cycle -> ESTABLISHED, no tx_valid, no conn_fail; duplicate SYN seq=100 in SYN_RCVD -> SYN-ACK resent, retry count unchanged.
